// File: rtl/uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_sequencer
// Purpose  : Streams a run-time-sized block of bytes from the transmit buffer
//            RAM into the UART transmitter. Generates buffer read addresses,
//            pulses the transmitter enable once per byte, waits for each
//            byte's completion, and reports busy / done / aborted status.
// Ports    : clk, rst            - clock, asynchronous active-low reset
//            tick_en_i           - baud tick enable; FSM moves only on ticks
//            start_i             - frame request (sampled in IDLE)
//            base_addr_i         - first buffer address, latched at start
//            frame_len_i         - byte count, latched at start
//            abort_i             - terminate the current frame
//            tx_done_i           - transmitter byte-complete indication
//            addr_o              - registered buffer read address
//            tx_ena_o            - one-tick transmit enable per byte
//            busy_o              - high while a frame is in progress
//            frame_done_o        - one-tick pulse on normal completion
//            aborted_o           - one-tick pulse on abort termination
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int LEN_W     = 4,
    parameter int GAP_TICKS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic              abort_i,
    input  logic              tx_done_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tx_ena_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              aborted_o
);

    localparam int c_GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_TICKS);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [c_GAP_W-1:0]  gap_q, gap_d;
    logic                abort_lat_q, abort_lat_d;
    logic                tx_ena_q, tx_ena_d;
    logic                frame_done_q, frame_done_d;
    logic                aborted_q, aborted_d;

    logic [LEN_W-1:0]    w_idx_nxt;

    assign w_idx_nxt = idx_q + LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            abort_lat_q  <= 1'b0;
            tx_ena_q     <= 1'b0;
            frame_done_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            abort_lat_q  <= abort_lat_d;
            tx_ena_q     <= tx_ena_d;
            frame_done_q <= frame_done_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        // Everything holds between ticks, including the pulse outputs.
        state_d      = state_q;
        addr_d       = addr_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        abort_lat_d  = abort_lat_q;
        tx_ena_d     = tx_ena_q;
        frame_done_d = frame_done_q;
        aborted_d    = aborted_q;

        if (tick_en_i) begin
            // Pulses last exactly one tick period.
            tx_ena_d     = 1'b0;
            frame_done_d = 1'b0;
            aborted_d    = 1'b0;

            case (state_q)
                S_IDLE: begin
                    abort_lat_d = 1'b0;
                    if (start_i) begin
                        if (frame_len_i != '0) begin
                            base_d  = base_addr_i;
                            len_d   = frame_len_i;
                            idx_d   = '0;
                            addr_d  = base_addr_i;
                            state_d = S_LOAD;
                        end else begin
                            frame_done_d = 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (abort_i) begin
                        aborted_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end

                S_SEND: begin
                    if (abort_i) begin
                        aborted_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        tx_ena_d = 1'b1;
                        state_d  = S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Abort is deferred so the byte in flight completes.
                    abort_lat_d = abort_lat_q | abort_i;
                    if (tx_done_i) begin
                        if (abort_lat_q || abort_i) begin
                            abort_lat_d = 1'b0;
                            aborted_d   = 1'b1;
                            state_d     = S_IDLE;
                        end else if (w_idx_nxt == len_q) begin
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            idx_d  = w_idx_nxt;
                            addr_d = base_q + ADDR_W'(w_idx_nxt);
                            if (GAP_TICKS > 0) begin
                                gap_d   = c_GAP_LOAD;
                                state_d = S_GAP;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (abort_i) begin
                        aborted_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (gap_q <= c_GAP_ONE) begin
                        gap_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        gap_d = gap_q - c_GAP_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign addr_o       = addr_q;
    assign tx_ena_o     = tx_ena_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;
    assign aborted_o    = aborted_q;

endmodule
`default_nettype wire
